// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Execute-stage sequencer on the requester side of the ALU start/done interface.
// It accepts one decoded op per req handshake and starts the ALU with a one-cycle
// enable. It then waits for the done level and returns result/zero/taken/tag/err
// over the rsp handshake. Only one op is in flight at a time.
//
// Ports
//   clk, reset             clock (posedge) and synchronous active-high reset
//   req_valid_i/ready_o    request handshake; ready only while idle
//   req_op_i               0000 ADD, 0001 SUB, 0010 AND, 0011 OR, others illegal
//   req_a_i, req_b_i       operands
//   req_br_i               00 none, 01 BEQ, 10 BNE, 11 none
//   req_tag_i              tag echoed on the response
//   ctrl_alu_op_enable     ALU start pulse
//   operand1/2, alu_control  registered ALU inputs
//   alu_result_i, stat_execution_done  ALU result and done level
//   rsp_valid_o/ready_i    response handshake
//   rsp_result_o, rsp_zero_o, rsp_taken_o, rsp_tag_o, rsp_err_o  response payload
//
// state   | meaning
// S_IDLE  | ready for a request
// S_ISSUE | ALU start pulse, operands presented
// S_WAIT  | counting cycles until done or timeout
// S_RESP  | response valid, held until accepted
module alu_issue_ctrl #(
   parameter int ALU_LATENCY = 1,
   parameter int TIMEOUT     = 16,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [3:0]       req_op_i,
   input  logic [31:0]      req_a_i,
   input  logic [31:0]      req_b_i,
   input  logic [1:0]       req_br_i,
   input  logic [TAG_W-1:0] req_tag_i,
   output logic             ctrl_alu_op_enable,
   output logic [31:0]      operand1,
   output logic [31:0]      operand2,
   output logic [3:0]       alu_control,
   input  logic [31:0]      alu_result_i,
   input  logic             stat_execution_done,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_result_o,
   output logic             rsp_zero_o,
   output logic             rsp_taken_o,
   output logic [TAG_W-1:0] rsp_tag_o,
   output logic [1:0]       rsp_err_o
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [3:0]         r_op;
   logic [31:0]        r_a;
   logic [31:0]        r_b;
   logic [1:0]         r_br;
   logic [TAG_W-1:0]   r_tag;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [31:0]        r_result;
   logic               r_zero;
   logic               r_taken;
   logic [1:0]         r_err;

   logic               w_accept;
   logic               w_illegal;
   logic               w_capture;
   logic               w_timeout;
   logic               w_res_zero;
   logic               w_br_taken;

   always_comb begin
      w_accept   = (r_state == S_IDLE) && req_valid_i;
      w_illegal  = (req_op_i[3:2] != 2'b00);
      // Capture wins over timeout when both hit on the same WAIT cycle.
      w_capture  = (r_state == S_WAIT) && stat_execution_done &&
                   (r_wait_cnt >= CNT_W'(ALU_LATENCY));
      w_timeout  = (r_state == S_WAIT) && !w_capture &&
                   (r_wait_cnt == CNT_W'(TIMEOUT));
      w_res_zero = (alu_result_i == 32'd0);
      w_br_taken = 1'b0;
      if (r_br == 2'b01) begin
         w_br_taken = w_res_zero;
      end else if (r_br == 2'b10) begin
         w_br_taken = !w_res_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      req_ready_o        = 1'b0;
      ctrl_alu_op_enable = 1'b0;
      rsp_valid_o        = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready_o = 1'b1;
            if (w_accept) begin
               w_state_nxt = w_illegal ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            ctrl_alu_op_enable = 1'b1;
            w_state_nxt        = S_WAIT;
         end
         S_WAIT: begin
            if (w_capture || w_timeout) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op       <= 4'd0;
         r_a        <= 32'd0;
         r_b        <= 32'd0;
         r_br       <= 2'd0;
         r_tag      <= '0;
         r_wait_cnt <= '0;
         r_result   <= 32'd0;
         r_zero     <= 1'b0;
         r_taken    <= 1'b0;
         r_err      <= 2'd0;
      end else begin
         if (w_accept) begin
            r_op  <= req_op_i;
            r_a   <= req_a_i;
            r_b   <= req_b_i;
            r_br  <= req_br_i;
            r_tag <= req_tag_i;
            if (w_illegal) begin
               r_result <= 32'd0;
               r_zero   <= 1'b1;
               r_taken  <= 1'b0;
               r_err    <= 2'b01;
            end
         end
         if (r_state == S_ISSUE) begin
            r_wait_cnt <= CNT_W'(1);
         end
         if (r_state == S_WAIT) begin
            if (w_capture) begin
               r_result   <= alu_result_i;
               r_zero     <= w_res_zero;
               r_taken    <= w_br_taken;
               r_err      <= 2'b00;
               r_wait_cnt <= '0;
            end else if (w_timeout) begin
               // A timed-out op never redirects the PC.
               r_result   <= 32'd0;
               r_zero     <= 1'b1;
               r_taken    <= 1'b0;
               r_err      <= 2'b10;
               r_wait_cnt <= '0;
            end else begin
               r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign operand1     = r_a;
   assign operand2     = r_b;
   assign alu_control  = r_op;
   assign rsp_result_o = r_result;
   assign rsp_zero_o   = r_zero;
   assign rsp_taken_o  = r_taken;
   assign rsp_tag_o    = r_tag;
   assign rsp_err_o    = r_err;

endmodule
